stack_param: RTL and testbench

- Parametrised LIFO stack; successor to the fixed 4-bit x 5-entry stack block.
- Same command set (NOP/PUSH/POP/GET), with these changes:
  - configurable width and depth;
  - separate input and output data buses (no inout);
  - full/empty/count status;
  - error reporting;
  - selectable overflow mode.
- Sits between a command-issuing controller and the datapath; one command per clock.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_mem.sv | 26 ++
 rtl/stack_param.sv | 111 +++++++++++
 tb/tb_stack_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - command encoding and circular pointer helpers for stack_param
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    // Explicit wrap so non-power-of-two depths stay inside 0..depth-1
    function automatic int inc_wrap(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int dec_wrap(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH register array, one write port, one combinational read port
module stack_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDXW-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDXW-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only entries below COUNT are ever read out
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised circular LIFO stack with status, error and overflow mode
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 5,
    parameter int OVERWRITE = 0,
    parameter int IDXW      = $clog2(DEPTH),
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IDXW-1:0]  INDEX,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             ERR,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CNTW-1:0]  COUNT
);

    cmd_e             cmd;
    logic [IDXW-1:0]  top_ptr;
    logic [IDXW-1:0]  top_inc;
    logic [IDXW-1:0]  top_dec;
    logic [IDXW-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             get_ok;
    logic             push_wr;
    int               get_addr;

    assign cmd     = cmd_e'(COMMAND);
    assign FULL    = (int'(COUNT) == DEPTH);
    assign EMPTY   = (COUNT == '0);
    assign get_ok  = (int'(INDEX) < int'(COUNT));
    assign top_inc = IDXW'(inc_wrap(int'(top_ptr), DEPTH));
    assign top_dec = IDXW'(dec_wrap(int'(top_ptr), DEPTH));
    assign push_wr = RESET && (cmd == CMD_PUSH) && (!FULL || (OVERWRITE != 0));

    // GET address is top-1-INDEX modulo DEPTH; valid INDEX keeps the sum below 2*DEPTH
    always_comb begin
        get_addr = int'(top_ptr) + DEPTH - 1 - int'(INDEX);
        if (get_addr >= DEPTH) begin
            get_addr = get_addr - DEPTH;
        end
        rd_addr = top_dec;
        if (cmd == CMD_GET && get_ok) begin
            rd_addr = IDXW'(get_addr);
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_mem (
        .clk     (CLK),
        .we      (push_wr),
        .wr_addr (top_ptr),
        .wr_data (DIN),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            top_ptr    <= '0;
            COUNT      <= '0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DOUT_VALID <= 1'b0;
            ERR        <= 1'b0;
            case (cmd)
                CMD_PUSH: begin
                    if (!FULL) begin
                        top_ptr <= top_inc;
                        COUNT   <= COUNT + CNTW'(1);
                    end else if (OVERWRITE != 0) begin
                        top_ptr <= top_inc;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                CMD_POP: begin
                    if (!EMPTY) begin
                        DOUT       <= rd_data;
                        DOUT_VALID <= 1'b1;
                        top_ptr    <= top_dec;
                        COUNT      <= COUNT - CNTW'(1);
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                CMD_GET: begin
                    if (get_ok) begin
                        DOUT       <= rd_data;
                        DOUT_VALID <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - directed self-checking bench for stack_param (rejecting and overwriting variants)
module tb_stack_param;
    import stack_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [1:0] command;
    logic [2:0] index;
    logic [3:0] din;

    logic [3:0] dout0, dout1;
    logic       dv0, dv1, err0, err1, full0, full1, empty0, empty1;
    logic [2:0] count0, count1;

    int n_tests = 0;
    int n_fail  = 0;

    stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) dut_rej (
        .CLK(clk), .RESET(reset_n), .COMMAND(command), .INDEX(index), .DIN(din),
        .DOUT(dout0), .DOUT_VALID(dv0), .ERR(err0), .FULL(full0), .EMPTY(empty0), .COUNT(count0)
    );

    stack_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(1)) dut_ovw (
        .CLK(clk), .RESET(reset_n), .COMMAND(command), .INDEX(index), .DIN(din),
        .DOUT(dout1), .DOUT_VALID(dv1), .ERR(err1), .FULL(full1), .EMPTY(empty1), .COUNT(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [1:0] c, input logic [2:0] i, input logic [3:0] d);
        @(negedge clk);
        command = c;
        index   = i;
        din     = d;
        @(posedge clk);
        #1;
        command = CMD_NOP;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        command = CMD_NOP;
        index   = '0;
        din     = '0;
        #3;
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_count", count0, 0);
        check("rst_dout", dout0, 0);
        check("rst_err", err0, 0);
        check("rst_dv", dv0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // POP on empty
        op(CMD_POP, 0, 0);
        check("pop_empty_err", err0, 1);
        check("pop_empty_dv", dv0, 0);
        check("pop_empty_dout", dout0, 0);
        check("pop_empty_empty", empty0, 1);
        check("pop_empty_count", count0, 0);
        op(CMD_NOP, 0, 0);
        check("err_one_cycle", err0, 0);
        op(CMD_GET, 0, 0);
        check("get_empty_err", err0, 1);

        // GET by index
        op(CMD_PUSH, 0, 1);
        op(CMD_PUSH, 0, 2);
        op(CMD_PUSH, 0, 3);
        op(CMD_GET, 0, 0);
        check("get0_dout", dout0, 3);
        check("get0_dv", dv0, 1);
        op(CMD_GET, 1, 0);
        check("get1_dout", dout0, 2);
        op(CMD_GET, 2, 0);
        check("get2_dout", dout0, 1);
        op(CMD_GET, 3, 0);
        check("get3_err", err0, 1);
        check("get3_dv", dv0, 0);
        check("get3_dout_held", dout0, 1);
        check("get3_count", count0, 3);
        op(CMD_GET, 7, 0);
        check("get7_err", err0, 1);
        check("get7_dout_held", dout0, 1);

        // Overflow, both modes
        do_reset();
        for (int k = 1; k <= 5; k++) op(CMD_PUSH, 0, 4'(k));
        check("fill_full", full0, 1);
        check("fill_count", count0, 5);
        op(CMD_PUSH, 0, 6);
        check("ovf_rej_err", err0, 1);
        check("ovf_rej_count", count0, 5);
        check("ovf_rej_full", full0, 1);
        check("ovf_ow_err", err1, 0);
        check("ovf_ow_count", count1, 5);
        for (int k = 0; k < 5; k++) begin
            op(CMD_POP, 0, 0);
            check($sformatf("rej_pop%0d", k), dout0, 5 - k);
            check($sformatf("ow_pop%0d", k), dout1, 6 - k);
            check($sformatf("ow_pop_dv%0d", k), dv1, 1);
        end
        check("drain_empty0", empty0, 1);
        check("drain_empty1", empty1, 1);
        op(CMD_POP, 0, 0);
        check("ow_pop6_err", err1, 1);
        check("ow_pop6_dout", dout1, 2);

        // Interleaved push/pop and pointer wrap
        do_reset();
        op(CMD_PUSH, 0, 4'hA);
        op(CMD_PUSH, 0, 4'hB);
        op(CMD_PUSH, 0, 4'hC);
        op(CMD_POP, 0, 0);
        check("mix_pop_c", dout0, 4'hC);
        op(CMD_PUSH, 0, 4'hD);
        op(CMD_POP, 0, 0);
        check("mix_pop_d", dout0, 4'hD);
        op(CMD_POP, 0, 0);
        check("mix_pop_b", dout0, 4'hB);
        for (int k = 1; k <= 4; k++) begin
            op(CMD_PUSH, 0, 4'(k));
            op(CMD_POP, 0, 0);
            check($sformatf("pair%0d", k), dout0, k);
        end
        for (int k = 5; k <= 8; k++) op(CMD_PUSH, 0, 4'(k));
        check("wrap_full", full0, 1);
        op(CMD_GET, 4, 0);
        check("wrap_get4", dout0, 4'hA);
        op(CMD_GET, 1, 0);
        check("wrap_get1", dout0, 7);
        for (int k = 8; k >= 5; k--) begin
            op(CMD_POP, 0, 0);
            check($sformatf("wrap_pop%0d", k), dout0, k);
        end
        op(CMD_POP, 0, 0);
        check("wrap_pop_a", dout0, 4'hA);
        check("wrap_empty", empty0, 1);

        // Asynchronous reset mid-sequence
        do_reset();
        op(CMD_PUSH, 0, 1);
        op(CMD_PUSH, 0, 2);
        op(CMD_PUSH, 0, 3);
        op(CMD_GET, 0, 0);
        check("pre_areset_count", count0, 3);
        check("pre_areset_dout", dout0, 3);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset_count", count0, 0);
        check("areset_empty", empty0, 1);
        check("areset_dout", dout0, 0);
        check("areset_dv", dv0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        op(CMD_PUSH, 0, 7);
        check("post_push_count", count0, 1);
        op(CMD_POP, 0, 0);
        check("post_pop_dout", dout0, 7);
        check("post_pop_dv", dv0, 1);
        check("post_pop_empty", empty0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
